// File: rtl/lock_pkg.sv
// Shared types, default timing parameters and step-entry helpers for the airlock operator.
package lock_pkg;

  localparam int KEY_PULSE_DEF = 4;
  localparam int DWELL_DEF     = 16;
  localparam int TIMEOUT_DEF   = 1024;
  localparam int CNT_W         = 16;

  typedef enum logic [4:0] {
    ST_IDLE       = 5'd0,
    ST_PRESS_KEY  = 5'd1,
    ST_PRESS_WAIT = 5'd2,
    ST_OUT_OPEN   = 5'd3,
    ST_OUT_DWELL  = 5'd4,
    ST_OUT_CLOSE  = 5'd5,
    ST_EVAC_KEY   = 5'd6,
    ST_EVAC_WAIT  = 5'd7,
    ST_IN_OPEN    = 5'd8,
    ST_IN_DWELL   = 5'd9,
    ST_IN_CLOSE   = 5'd10,
    ST_DONE       = 5'd11,
    ST_ERROR      = 5'd12
  } lock_state_e;

  typedef enum logic {
    DIR_ARRIVE = 1'b0,
    DIR_DEPART = 1'b1
  } lock_dir_e;

  // A pressure step whose target already reads 1 is skipped straight to the next port opening.
  function automatic lock_state_e press_entry(input logic pressurized);
    return pressurized ? ST_OUT_OPEN : ST_PRESS_KEY;
  endfunction

  function automatic lock_state_e evac_entry(input logic evacuated);
    return evacuated ? ST_IN_OPEN : ST_EVAC_KEY;
  endfunction

endpackage

// File: rtl/step_timer.sv
// Per-step cycle counter: cleared on load, counts while enabled, flags the last cycle of the limit.
module step_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_count,
  input  logic [W-1:0] i_limit,
  output logic         o_expired
);

  logic [W-1:0] r_count;

  // Expired marks the final cycle, so the owning step lasts exactly i_limit cycles.
  assign o_expired = (r_count == i_limit - W'(1));

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= '0;
    end else if (i_count && !o_expired) begin
      r_count <= r_count + W'(1);
    end
  end

endmodule

// File: rtl/lock_operator.sv
// Airlock sequencer: drives port toggles and pressure keys through arrival/departure step orders.
module lock_operator
  import lock_pkg::*;
#(
  parameter int KEY_PULSE = KEY_PULSE_DEF,
  parameter int DWELL     = DWELL_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arrive_req,
  input  logic       depart_req,
  input  logic       outer_closed,
  input  logic       inner_closed,
  input  logic       pressurized,
  input  logic       evacuated,
  output logic       arrive_sw,
  output logic       depart_sw,
  output logic       outer_sw,
  output logic       inner_sw,
  output logic       fp_key_n,
  output logic       ev_key_n,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [4:0] state
);

  lock_state_e      r_state;
  lock_dir_e        r_dir;
  logic             r_arrive_sw;
  logic             r_depart_sw;
  logic             r_outer_sw;
  logic             r_inner_sw;

  lock_state_e      w_next;
  logic             w_enter;
  logic             w_accept;
  logic             w_count;
  logic             w_expired;
  logic             w_ports_closed;
  logic [CNT_W-1:0] w_limit;

  assign w_ports_closed = outer_closed && inner_closed;
  assign w_enter        = (w_next != r_state);
  assign w_accept       = (r_state == ST_IDLE) && (w_next != ST_IDLE) && (w_next != ST_ERROR);
  assign w_count        = (r_state != ST_IDLE) && (r_state != ST_ERROR);

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (arrive_req || depart_req) begin
          if (!w_ports_closed)  w_next = ST_ERROR;
          else if (arrive_req)  w_next = press_entry(pressurized);
          else                  w_next = evac_entry(evacuated);
        end
      end
      ST_PRESS_KEY:  if (w_expired) w_next = ST_PRESS_WAIT;
      ST_PRESS_WAIT: begin
        if (pressurized)    w_next = ST_OUT_OPEN;
        else if (w_expired) w_next = ST_ERROR;
      end
      ST_OUT_OPEN: begin
        if (!outer_closed)  w_next = ST_OUT_DWELL;
        else if (w_expired) w_next = ST_ERROR;
      end
      ST_OUT_DWELL:  if (w_expired) w_next = ST_OUT_CLOSE;
      ST_OUT_CLOSE: begin
        if (outer_closed)   w_next = (r_dir == DIR_ARRIVE) ? evac_entry(evacuated) : ST_DONE;
        else if (w_expired) w_next = ST_ERROR;
      end
      ST_EVAC_KEY:   if (w_expired) w_next = ST_EVAC_WAIT;
      ST_EVAC_WAIT: begin
        if (evacuated)      w_next = ST_IN_OPEN;
        else if (w_expired) w_next = ST_ERROR;
      end
      ST_IN_OPEN: begin
        if (!inner_closed)  w_next = ST_IN_DWELL;
        else if (w_expired) w_next = ST_ERROR;
      end
      ST_IN_DWELL:   if (w_expired) w_next = ST_IN_CLOSE;
      ST_IN_CLOSE: begin
        if (inner_closed)   w_next = (r_dir == DIR_ARRIVE) ? ST_DONE : press_entry(pressurized);
        else if (w_expired) w_next = ST_ERROR;
      end
      ST_DONE:       w_next = ST_IDLE;
      ST_ERROR:      w_next = ST_ERROR;
      default:       w_next = ST_ERROR;
    endcase
  end

  always_comb begin
    w_limit = CNT_W'(TIMEOUT);
    case (r_state)
      ST_PRESS_KEY, ST_EVAC_KEY: w_limit = CNT_W'(KEY_PULSE);
      ST_OUT_DWELL, ST_IN_DWELL: w_limit = CNT_W'(DWELL);
      default:                   w_limit = CNT_W'(TIMEOUT);
    endcase
  end

  step_timer #(.W(CNT_W)) u_step_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_enter),
    .i_count   (w_count),
    .i_limit   (w_limit),
    .o_expired (w_expired)
  );

  // Port commands toggle on step entry so the first command appears one cycle after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_dir       <= DIR_ARRIVE;
      r_arrive_sw <= 1'b0;
      r_depart_sw <= 1'b0;
      r_outer_sw  <= 1'b0;
      r_inner_sw  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_dir       <= arrive_req ? DIR_ARRIVE : DIR_DEPART;
        r_arrive_sw <= arrive_req;
        r_depart_sw <= !arrive_req;
      end else if (w_enter && (w_next == ST_DONE)) begin
        r_arrive_sw <= 1'b0;
        r_depart_sw <= 1'b0;
      end
      if (w_enter && ((w_next == ST_OUT_OPEN) || (w_next == ST_OUT_CLOSE))) begin
        r_outer_sw <= ~r_outer_sw;
      end
      if (w_enter && ((w_next == ST_IN_OPEN) || (w_next == ST_IN_CLOSE))) begin
        r_inner_sw <= ~r_inner_sw;
      end
    end
  end

  // Keys are additionally gated by both closed statuses so an open port can never see a key.
  assign fp_key_n  = !((r_state == ST_PRESS_KEY) && w_ports_closed);
  assign ev_key_n  = !((r_state == ST_EVAC_KEY) && w_ports_closed);
  assign arrive_sw = r_arrive_sw;
  assign depart_sw = r_depart_sw;
  assign outer_sw  = r_outer_sw;
  assign inner_sw  = r_inner_sw;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign error     = (r_state == ST_ERROR);
  assign state     = r_state;

endmodule

// File: tb/tb_lock_operator.sv
// Directed bench for lock_operator with a small responsive interlock model.
module tb_lock_operator;
  import lock_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       arrive_req = 1'b0;
  logic       depart_req = 1'b0;
  logic       outer_closed = 1'b1;
  logic       inner_closed = 1'b1;
  logic       pressurized = 1'b0;
  logic       evacuated = 1'b1;
  logic       arrive_sw, depart_sw, outer_sw, inner_sw;
  logic       fp_key_n, ev_key_n, busy, done, error;
  logic [4:0] state;

  int n_checks = 0;
  int n_errors = 0;

  // interlock model controls and history
  bit         press_ok = 1'b1;
  bit         inner_force_open = 1'b0;
  logic [2:0] out_hist = 3'b000;
  logic [2:0] in_hist = 3'b000;
  logic       prev_fp = 1'b1;
  logic       prev_ev = 1'b1;

  // observation results
  int   fp_low, ev_low, outer_tog, inner_tog, done_cnt, first_tog, viol;
  bit   seq_timeout;
  logic pre_o, pre_i;

  lock_operator dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .arrive_req   (arrive_req),
    .depart_req   (depart_req),
    .outer_closed (outer_closed),
    .inner_closed (inner_closed),
    .pressurized  (pressurized),
    .evacuated    (evacuated),
    .arrive_sw    (arrive_sw),
    .depart_sw    (depart_sw),
    .outer_sw     (outer_sw),
    .inner_sw     (inner_sw),
    .fp_key_n     (fp_key_n),
    .ev_key_n     (ev_key_n),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .state        (state)
  );

  always #5 clk = ~clk;

  // Ports follow their sw level with a short lag; pressure flips when a key pulse ends.
  always @(negedge clk) begin
    out_hist     = {out_hist[1:0], outer_sw};
    in_hist      = {in_hist[1:0], inner_sw};
    outer_closed = !out_hist[2];
    inner_closed = !in_hist[2] && !inner_force_open;
    if (!prev_fp && fp_key_n && press_ok) begin
      pressurized = 1'b1;
      evacuated   = 1'b0;
    end
    if (!prev_ev && ev_key_n) begin
      evacuated   = 1'b1;
      pressurized = 1'b0;
    end
    prev_fp = fp_key_n;
    prev_ev = ev_key_n;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_req(input logic a, input logic d);
    pre_o      = outer_sw;
    pre_i      = inner_sw;
    arrive_req = a;
    depart_req = d;
    step();
    arrive_req = 1'b0;
    depart_req = 1'b0;
  endtask

  task automatic observe(input int budget);
    logic p_o, p_i;
    bit   seen_end;
    int   tail;
    fp_low = 0; ev_low = 0; outer_tog = 0; inner_tog = 0;
    done_cnt = 0; first_tog = 0; viol = 0;
    seen_end = 1'b0; tail = 0;
    p_o = pre_o;
    p_i = pre_i;
    for (int c = 0; c < budget && tail < 2; c++) begin
      if (!fp_key_n) fp_low++;
      if (!ev_key_n) ev_low++;
      if (!fp_key_n && !ev_key_n) viol++;
      if ((!fp_key_n || !ev_key_n) && (!outer_closed || !inner_closed)) viol++;
      if (outer_sw != p_o) begin
        outer_tog++;
        if (first_tog == 0) first_tog = 1;
      end
      if (inner_sw != p_i) begin
        inner_tog++;
        if (first_tog == 0) first_tog = 2;
      end
      if (done) done_cnt++;
      if (done || error) seen_end = 1'b1;
      if (seen_end) tail++;
      p_o = outer_sw;
      p_i = inner_sw;
      step();
    end
    seq_timeout = !seen_end;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    bit found;

    // reset state
    step();
    check("rst_state", state, ST_IDLE);
    check("rst_sw", {arrive_sw, depart_sw, outer_sw, inner_sw}, 4'b0000);
    check("rst_keys", {fp_key_n, ev_key_n}, 2'b11);
    check("rst_flags", {busy, done, error}, 3'b000);
    step();
    rst_n = 1'b1;
    repeat (3) step();

    // arrival from evacuated: press, outer cycle, evacuate, inner cycle
    pulse_req(1'b1, 1'b0);
    check("arr_latency_key", fp_key_n, 1'b0);
    check("arr_sw", arrive_sw, 1'b1);
    check("arr_busy", busy, 1'b1);
    observe(400);
    check("arr_timeout", seq_timeout, 1'b0);
    check("arr_fp_low", fp_low, 4);
    check("arr_ev_low", ev_low, 4);
    check("arr_outer_tog", outer_tog, 2);
    check("arr_inner_tog", inner_tog, 2);
    check("arr_first_port", first_tog, 1);
    check("arr_done", done_cnt, 1);
    check("arr_error", error, 1'b0);
    check("arr_key_safety", viol, 0);
    check("arr_sw_end", arrive_sw, 1'b0);
    check("arr_idle", state, ST_IDLE);

    // departure from evacuated: evacuate skipped, inner first
    pulse_req(1'b0, 1'b1);
    check("dep_sw", depart_sw, 1'b1);
    check("dep_inner_first", inner_sw, 1'b1);
    check("dep_no_ev", ev_key_n, 1'b1);
    observe(400);
    check("dep_timeout", seq_timeout, 1'b0);
    check("dep_ev_low", ev_low, 0);
    check("dep_fp_low", fp_low, 4);
    check("dep_first_port", first_tog, 2);
    check("dep_inner_tog", inner_tog, 2);
    check("dep_outer_tog", outer_tog, 2);
    check("dep_done", done_cnt, 1);
    check("dep_outer_closed", outer_closed, 1'b1);
    check("dep_key_safety", viol, 0);
    check("dep_error", error, 1'b0);

    // simultaneous requests: arrival wins; pressurized so press is skipped
    pulse_req(1'b1, 1'b1);
    check("both_arrive_sw", arrive_sw, 1'b1);
    check("both_depart_sw", depart_sw, 1'b0);
    check("both_outer_now", outer_sw, 1'b1);
    check("both_no_fp", fp_key_n, 1'b1);
    repeat (10) step();
    pulse_req(1'b0, 1'b1);
    check("busy_req_ignored", depart_sw, 1'b0);
    observe(400);
    check("both_timeout", seq_timeout, 1'b0);
    check("both_done", done_cnt, 1);
    repeat (3) step();
    check("no_queue_busy", busy, 1'b0);
    check("no_queue_state", state, ST_IDLE);

    // pressurization never confirmed
    press_ok = 1'b0;
    pulse_req(1'b1, 1'b0);
    check("to_key_low", fp_key_n, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (fp_key_n) found = 1'b1;
      else step();
    end
    check("to_key_release", found, 1'b1);
    t = 0;
    while (!error && t < 1200) begin
      step();
      t++;
    end
    check("to_cycles", t, 1024);
    check("to_error", error, 1'b1);
    check("to_fp_released", fp_key_n, 1'b1);
    check("to_ev_released", ev_key_n, 1'b1);
    check("to_state", state, ST_ERROR);
    pulse_req(1'b1, 1'b0);
    repeat (3) step();
    check("to_req_ignored", state, ST_ERROR);
    check("to_sw_held", arrive_sw, 1'b1);
    check("to_no_done", done, 1'b0);

    // inner port open at request time
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    press_ok = 1'b1;
    inner_force_open = 1'b1;
    repeat (2) step();
    pulse_req(1'b1, 1'b0);
    check("pre_state", state, ST_ERROR);
    check("pre_error", error, 1'b1);
    check("pre_keys", {fp_key_n, ev_key_n}, 2'b11);
    check("pre_sw", {arrive_sw, depart_sw, outer_sw, inner_sw}, 4'b0000);

    // reset in the middle of the outer dwell
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    inner_force_open = 1'b0;
    repeat (4) step();
    pulse_req(1'b1, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (state == ST_OUT_DWELL) found = 1'b1;
      else step();
    end
    check("mid_reach_dwell", found, 1'b1);
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    check("mid_state", state, ST_IDLE);
    check("mid_sw", {arrive_sw, depart_sw, outer_sw, inner_sw}, 4'b0000);
    check("mid_keys", {fp_key_n, ev_key_n}, 2'b11);
    check("mid_flags", {busy, done, error}, 3'b000);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (6) step();
    check("mid_outer_reclosed", outer_closed, 1'b1);
    pulse_req(1'b1, 1'b0);
    observe(400);
    check("re_timeout", seq_timeout, 1'b0);
    check("re_done", done_cnt, 1);
    check("re_error", error, 1'b0);
    check("re_fp_low", fp_low, 0);
    check("re_ev_low", ev_low, 4);
    check("re_outer_tog", outer_tog, 2);
    check("re_inner_tog", inner_tog, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
